// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- runtime-configurable UART transmitter.
//
// Sends one frame per accepted word. A frame is a start bit, 5..DBIT_MAX data
// bits (LSB first), an optional parity bit (odd/even/mark) and 1 or 2 stop
// bits. The bit period is OVERSAMPLE*(cfg_div+1) clocks. The frame format is
// captured at accept, so the cfg_* inputs may change freely mid-frame. The
// exception is cfg_div, which must stay static while a frame is in progress.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   cfg_div        baud divisor: tick period = cfg_div+1 clocks
//   cfg_dbits      data bits per frame (clamped to 5..DBIT_MAX at capture)
//   cfg_parity     00 none, 01 odd, 10 even, 11 mark
//   cfg_stop2      0 = one stop bit, 1 = two stop bits
//   tx_valid/ready word handshake; tx_data is sent LSB first
//   tx_done_tick   one-cycle pulse at the end of the final stop bit
//   busy           frame (or break) in progress
//   tx             registered serial line, idle high
//   tx_break       (only with UART_TX_BREAK_EN) hold line low while high,
//                  followed by one bit period of mark before returning to idle
//
// Optional feature macro: UART_TX_BREAK_EN
module uart_tx_cfg #(
  parameter int unsigned DBIT_MAX   = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DIV_W-1:0]                  cfg_div,
  input  logic [$clog2(DBIT_MAX+1)-1:0]     cfg_dbits,
  input  logic [1:0]                        cfg_parity,
  input  logic                              cfg_stop2,
  input  logic                              tx_valid,
  input  logic [DBIT_MAX-1:0]               tx_data,
`ifdef UART_TX_BREAK_EN
  input  logic                              tx_break,
`endif
  output logic                              tx_ready,
  output logic                              tx_done_tick,
  output logic                              busy,
  output logic                              tx
);

  localparam int unsigned DBW = $clog2(DBIT_MAX + 1);
  localparam int unsigned NW  = (DBIT_MAX > 2) ? $clog2(DBIT_MAX) : 1;
  localparam int unsigned SW  = $clog2(2 * OVERSAMPLE);

  localparam logic [SW-1:0] S_BIT_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP2_LAST = SW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    , BREAK,
    MARK
`endif
  } state_t;

  state_t              state_q, state_n;
  logic [DIV_W-1:0]    div_cnt_q;
  logic [SW-1:0]       s_q, s_n;
  logic [NW-1:0]       n_q, n_n;
  logic [DBIT_MAX-1:0] shift_q, shift_n;
  logic [DBW-1:0]      dbits_q;
  logic                par_en_q;
  logic                par_bit_q;
  logic                stop2_q;

  logic                s_tick;
  logic                accept;
  logic                cnt_clr;
  logic                done_n;
  logic                busy_n;
  logic                tx_n;
  logic [DBW-1:0]      dbits_cap;
  logic                data_xor;
  logic                par_cap;

  // A word is refused in the done-pulse cycle so that the next start bit
  // lands two clocks after tx_done_tick.
  assign tx_ready = (state_q == IDLE) & ~tx_done_tick;
  assign accept   = tx_valid & tx_ready;
  assign s_tick   = (div_cnt_q == cfg_div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else if (cnt_clr || s_tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Frame format capture: clamp length, parity over the active bits only.
  always_comb begin
    dbits_cap = cfg_dbits;
    if (cfg_dbits < DBW'(5)) begin
      dbits_cap = DBW'(5);
    end else if (cfg_dbits > DBW'(DBIT_MAX)) begin
      dbits_cap = DBW'(DBIT_MAX);
    end
    data_xor = 1'b0;
    for (int unsigned i = 0; i < DBIT_MAX; i++) begin
      if (DBW'(i) < dbits_cap) begin
        data_xor = data_xor ^ tx_data[i];
      end
    end
    case (cfg_parity)
      2'b01:   par_cap = ~data_xor;
      2'b10:   par_cap = data_xor;
      default: par_cap = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state_q;
    s_n     = s_q;
    n_n     = n_q;
    shift_n = shift_q;
    done_n  = 1'b0;
    cnt_clr = accept;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_n = START;
          s_n     = '0;
          shift_n = tx_data;
        end
`ifdef UART_TX_BREAK_EN
        else if (tx_break && !tx_done_tick) begin
          state_n = BREAK;
        end
`endif
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_n     = '0;
            n_n     = '0;
            state_n = DATA;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_n     = '0;
            shift_n = shift_q >> 1;
            if (DBW'(n_q) == (dbits_q - DBW'(1))) begin
              state_n = par_en_q ? PARITY : STOP;
            end else begin
              n_n = n_q + 1'b1;
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_n     = '0;
            state_n = STOP;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == (stop2_q ? S_STOP2_LAST : S_BIT_LAST)) begin
            s_n     = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        // Restart the baud counter so mark-after-break is a full bit period.
        if (!tx_break) begin
          state_n = MARK;
          s_n     = '0;
          cnt_clr = 1'b1;
        end
      end
      MARK: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_n     = '0;
            state_n = IDLE;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // tx is registered from the next state so the line moves with the state.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_bit_q;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_n = 1'b0;
`endif
      default: tx_n = 1'b1;
    endcase

    busy_n = (state_n != IDLE) | done_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      shift_q      <= '0;
      dbits_q      <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      stop2_q      <= 1'b0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state_q      <= state_n;
      s_q          <= s_n;
      n_q          <= n_n;
      shift_q      <= shift_n;
      tx           <= tx_n;
      busy         <= busy_n;
      tx_done_tick <= done_n;
      if (accept) begin
        dbits_q   <= dbits_cap;
        par_en_q  <= |cfg_parity;
        par_bit_q <= par_cap;
        stop2_q   <= cfg_stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg -- bench for uart_tx_cfg (DBIT_MAX=8, OVERSAMPLE=16).
// A frame-level model expands each accepted word into its list of line bits
// and predicts tx/tx_ready/busy/tx_done_tick for every clock. Directed frames
// pin the model with hand-computed bit patterns and timings. Random frames
// then exercise the length clamp, all parity modes, stop bits, divisors and
// back-to-back transfers. The break sequence is checked when UART_TX_BREAK_EN
// is defined.
module tb_uart_tx_cfg;

  localparam int unsigned DBIT_MAX   = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DIV_W      = 16;

  logic        clk;
  logic        reset_n;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_dbits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_break;
  logic        tx_ready;
  logic        tx_done_tick;
  logic        busy;
  logic        tx;

  int compared   = 0;
  int mismatched = 0;

  uart_tx_cfg #(
    .DBIT_MAX  (DBIT_MAX),
    .OVERSAMPLE(OVERSAMPLE),
    .DIV_W     (DIV_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_div     (cfg_div),
    .cfg_dbits   (cfg_dbits),
    .cfg_parity  (cfg_parity),
    .cfg_stop2   (cfg_stop2),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
`ifdef UART_TX_BREAK_EN
    .tx_break    (tx_break),
`endif
    .tx_ready    (tx_ready),
    .tx_done_tick(tx_done_tick),
    .busy        (busy),
    .tx          (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- frame-level model ----------------
  int cyc     = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int m_c     = -1;  // clock index within the current frame, -1 when idle
  int m_L     = 0;   // frame length in clocks
  int m_P     = 16;  // bit period in clocks
  int m_mab   = -1;  // clock index within mark-after-break, -1 when not
  bit m_brk   = 1'b0;
  bit m_bits[16];

  always @(posedge clk or negedge reset_n) begin : model
    int d, ones, nb;
    if (!reset_n) begin
      m_c   = -1;
      m_mab = -1;
      m_brk = 1'b0;
    end else begin
      cyc++;
      if (m_brk) begin
        if (!tx_break) begin
          m_brk = 1'b0;
          m_mab = 0;
          m_P   = OVERSAMPLE * (int'(cfg_div) + 1);
        end
      end else if (m_mab >= 0) begin
        m_mab++;
        if (m_mab >= m_P) m_mab = -1;
      end else if (m_c >= 0) begin
        m_c++;
        if (m_c > m_L) m_c = -1;
      end else if (tx_valid) begin
        d = int'(cfg_dbits);
        if (d < 5) d = 5;
        if (d > 8) d = 8;
        ones = 0;
        m_bits[0] = 1'b0;
        for (int i = 0; i < d; i++) begin
          m_bits[1+i] = tx_data[i];
          if (tx_data[i]) ones++;
        end
        nb = 1 + d;
        if (cfg_parity != 2'b00) begin
          if (cfg_parity == 2'b11)      m_bits[nb] = 1'b1;
          else if (cfg_parity == 2'b10) m_bits[nb] = (ones % 2) == 1;
          else                          m_bits[nb] = (ones % 2) == 0;
          nb++;
        end
        m_bits[nb] = 1'b1;
        nb++;
        if (cfg_stop2) begin
          m_bits[nb] = 1'b1;
          nb++;
        end
        m_P     = OVERSAMPLE * (int'(cfg_div) + 1);
        m_L     = nb * m_P;
        m_c     = 0;
        acc_cnt++;
        acc_cyc = cyc;
      end else if (tx_break) begin
        m_brk = 1'b1;
      end
    end
  end

  // Per-cycle comparison: {tx, tx_ready, busy, tx_done_tick}
  always @(negedge clk) begin : compare
    logic [3:0] exp_v, act_v;
    if (m_brk)           exp_v = 4'b0010;
    else if (m_mab >= 0) exp_v = 4'b1010;
    else if (m_c < 0)    exp_v = 4'b1100;
    else if (m_c < m_L)  exp_v = {m_bits[m_c / m_P], 3'b010};
    else                 exp_v = 4'b1011;
    act_v = {tx, tx_ready, busy, tx_done_tick};
    compared++;
    if (act_v !== exp_v) begin
      mismatched++;
      $display("FAIL cycle_cmp cyc=%0d tx/rdy/busy/done got %b expected %b",
               cyc, act_v, exp_v);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act, input int exp_val);
    compared++;
    if (act != exp_val) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_val);
    end
  endtask

  task automatic at_cyc(input int base, input int off);
    while (cyc - base < off) @(negedge clk);
  endtask

  task automatic present(input logic [7:0] d, input int unsigned db,
                         input logic [1:0] par, input logic st2);
    @(negedge clk);
    tx_data    = d;
    cfg_dbits  = 4'(db);
    cfg_parity = par;
    cfg_stop2  = st2;
    tx_valid   = 1'b1;
  endtask

  task automatic wait_accept();
    int start, t;
    start = acc_cnt;
    t = 0;
    while (acc_cnt == start && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("accept_seen", int'(acc_cnt != start), 1);
  endtask

  // Returns in the first clock of the frame; scrambles the format inputs
  // (not cfg_div) so a mid-frame change is exercised on every frame.
  task automatic send(input logic [7:0] d, input int unsigned db,
                      input logic [1:0] par, input logic st2, input bit hold);
    present(d, db, par, st2);
    wait_accept();
    if (!hold) tx_valid = 1'b0;
    cfg_dbits  = 4'($urandom);
    cfg_parity = 2'($urandom);
    cfg_stop2  = 1'($urandom);
    tx_data    = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(m_c < 0 && !m_brk && m_mab < 0) && t < 30000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", int'(m_c < 0 && !m_brk && m_mab < 0), 1);
  endtask

  task automatic check_frame(input string nm, input int base, input int p,
                             input int nbits, input logic [15:0] bv);
    for (int i = 0; i < nbits; i++) begin
      at_cyc(base, i * p + p / 2);
      chk($sformatf("%s_bit%0d", nm, i), int'(tx), int'(bv[i]));
    end
    at_cyc(base, nbits * p - 1);
    chk({nm, "_done_early"}, int'(tx_done_tick), 0);
    at_cyc(base, nbits * p);
    chk({nm, "_done"}, int'(tx_done_tick), 1);
    chk({nm, "_ready_in_done"}, int'(tx_ready), 0);
    at_cyc(base, nbits * p + 1);
    chk({nm, "_done_single"}, int'(tx_done_tick), 0);
    chk({nm, "_ready_after"}, int'(tx_ready), 1);
  endtask

  // ---------------- stimulus ----------------
  bit prev_hold;
  bit hold;
  int a1;
  int cnt;

  initial begin
    reset_n    = 1'b0;
    cfg_div    = 16'd3;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_break   = 1'b0;
    prev_hold  = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(tx_done_tick), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5, cfg_div=3 -> 64-clock bits, done 640 clocks after accept
    cfg_div = 16'd3;
    send(8'hA5, 8, 2'b00, 1'b0, 1'b0);
    check_frame("a5_8n1", acc_cyc, 64, 10, 16'(10'b1101001010));
    wait_idle();

    // 7E2 0x53, cfg_div=0 -> 11 bits of 16 clocks = 176
    cfg_div = 16'd0;
    send(8'h53, 7, 2'b10, 1'b1, 1'b0);
    check_frame("53_7e2", acc_cyc, 16, 11, 16'(11'b11010100110));
    wait_idle();

    // 5O1 0xFF, cfg_div=1 -> 8 bits of 32 clocks
    cfg_div = 16'd1;
    send(8'hFF, 5, 2'b01, 1'b0, 1'b0);
    check_frame("ff_5o1", acc_cyc, 32, 8, 16'(8'b10111110));
    wait_idle();

    // Back-to-back with tx_valid held; format changed during frame one
    cfg_div = 16'd0;
    present(8'h01, 8, 2'b00, 1'b0);
    wait_accept();
    a1 = acc_cyc;
    @(negedge clk);
    tx_data    = 8'h80;
    cfg_dbits  = 4'd5;
    cfg_parity = 2'b10;
    cfg_stop2  = 1'b0;
    check_frame("b2b_first", a1, 16, 10, 16'(10'b1000000010));
    wait_accept();
    chk("b2b_gap_clocks", acc_cyc - a1, 162);
    tx_valid = 1'b0;
    check_frame("b2b_second", acc_cyc, 16, 8, 16'(8'b10000000));
    wait_idle();

    // Reset in the middle of DATA, then a clean 0x3C frame
    cfg_div = 16'd3;
    send(8'h96, 8, 2'b00, 1'b0, 1'b0);
    at_cyc(acc_cyc, 64 * 3 + 10);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_tx", int'(tx), 1);
    chk("midreset_ready", int'(tx_ready), 1);
    chk("midreset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    send(8'h3C, 8, 2'b00, 1'b0, 1'b0);
    check_frame("3c_after_reset", acc_cyc, 64, 10, 16'(10'b1001111000));
    wait_idle();

`ifdef UART_TX_BREAK_EN
    // Break for 1000 clocks, then one bit period of mark before ready
    cfg_div = 16'd3;
    @(negedge clk);
    tx_break = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx == 1'b0 && !tx_ready) cnt++;
    end
    tx_break = 1'b0;
    chk("break_low_clocks", cnt, 1000);
    cnt = 0;
    @(negedge clk);
    for (int i = 0; i < 200 && !tx_ready; i++) begin
      if (tx == 1'b1) cnt++;
      @(negedge clk);
    end
    chk("mark_after_break_clocks", cnt, 64);
    wait_idle();
`endif

    // Randomized frames: clamp range, all parity modes, stops, divisors
    for (int f = 0; f < 30; f++) begin
      hold = ($urandom_range(0, 3) == 0);
      if (!prev_hold) begin
        wait_idle();
        repeat ($urandom_range(0, 5)) @(negedge clk);
        cfg_div = 16'($urandom_range(0, 3));
      end
      send(8'($urandom), $urandom_range(0, 15), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), hold);
      prev_hold = hold;
    end
    tx_valid = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d",
             compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
